// File: rtl/umi_host_initiator.sv
// Host-side UMI initiator: issues one single-beat read or posted write at a time
// on uhost_req_*, collects the read response on uhost_resp_* and reports completion.
module umi_host_initiator #(
    parameter int             DW         = 256,
    parameter int             AW         = 64,
    parameter int             CW         = 32,
    parameter logic [AW-1:0]  SRCADDR    = '0,
    parameter logic [7:0]     OPC_WRITE  = 8'h01,
    parameter logic [7:0]     OPC_READ   = 8'h08,
    parameter logic [7:0]     OPC_RDRESP = 8'h09,
    parameter int             TIMEOUT    = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    // local command side
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata,
    // UMI request channel
    output logic          uhost_req_valid,
    input  logic          uhost_req_ready,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    // UMI response channel
    input  logic          uhost_resp_valid,
    output logic          uhost_resp_ready,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          is_write;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [31:0]   cnt;
    logic          err_q;
    logic [DW-1:0] rdata_q;
    logic          resp_ok;
    logic          timeout_hit;
    logic          unused;

    assign unused  = ^{uhost_resp_srcaddr, uhost_resp_cmd};
    assign resp_ok = (uhost_resp_cmd[7:0] == OPC_RDRESP) && (uhost_resp_dstaddr == SRCADDR);

    // Deadline lands the completion TIMEOUT cycles after the request handshake;
    // the first WAIT cycle has cnt==0, so the last WAIT cycle is cnt==TIMEOUT-2.
    assign timeout_hit = (cnt + 32'd2) >= 32'(TIMEOUT);

    always_ff @(posedge clk) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = REQ;
            REQ:     if (uhost_req_ready) state_nxt = is_write ? DONE : WAIT;
            WAIT:    if (uhost_resp_valid || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            is_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    is_write <= cmd_write;
                    addr_q   <= cmd_addr;
                    wdata_q  <= cmd_write ? cmd_wdata : '0;
                end
                REQ: if (uhost_req_ready) begin
                    cnt     <= '0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 32'd1;
                    // a response in the deadline cycle still wins over the timeout
                    if (uhost_resp_valid) begin
                        err_q   <= !resp_ok;
                        rdata_q <= resp_ok ? uhost_resp_data : '0;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        uhost_req_cmd = '0;
        if (state == REQ) uhost_req_cmd[7:0] = is_write ? OPC_WRITE : OPC_READ;
    end

    // ready outputs are held low while reset is asserted
    assign cmd_ready         = nreset && (state == IDLE);
    assign uhost_resp_ready  = nreset && ((state == IDLE) || (state == WAIT));
    assign uhost_req_valid   = (state == REQ);
    assign uhost_req_dstaddr = (state == REQ) ? addr_q  : '0;
    assign uhost_req_srcaddr = (state == REQ) ? SRCADDR : '0;
    assign uhost_req_data    = (state == REQ) ? wdata_q : '0;
    assign rsp_valid         = (state == DONE);
    assign rsp_err           = (state == DONE) && err_q;
    assign rsp_rdata         = (state == DONE) ? rdata_q : '0;

endmodule
